sram_a_seq_ctrl: RTL and testbench
==================================

Name: sram_a_seq_ctrl

Overview:
- Sequencing controller for the 8x8-bank A-operand SRAM array: 8 units, each of 8 banks, each bank written 32 bits at a time and read 4 bits at a time.
- Load phase: accepts a valid/ready word stream and steers each word to one bank through a one-hot write enable. Controller pulses the array reset before loading so bank write pointers start at 0.
- Feed phase: drives per-unit read addresses and read enables, skewed one cycle per unit for the systolic PE rows, plus a per-unit data-valid strobe.
- Sits between the DMA/AXI-side loader and the PE array.

Parameters:
- ENTRYS, 16, nibble entries per bank; multiple of 8, >= 8.
- WRWIDTH, 32, write word width; fixed at 8 nibbles.
- RDWIDTH, 4, read width per bank; informational only, not used in controller arithmetic.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_start  in  1  one-cycle command: clear and load the array
- feed_start  in  1  one-cycle command: stream stored tile to PEs
- in_valid  in  1  load word valid
- in_ready  out  1  load word accepted when in_valid && in_ready
- in_data  in  WRWIDTH  load word
- sram_rst  out  1  array reset; resets bank write pointers
- sram_we  out  [7:0][7:0]  per-unit, per-bank write enable; one-hot or zero
- sram_data_in  out  [7:0][7:0][WRWIDTH]  in_data broadcast to all banks
- sram_rdaddr  out  [7:0][$clog2(ENTRYS)]  per-unit read address
- sram_re  out  [7:0]  per-unit read enable
- row_valid  out  [7:0]  sram data_out[i] valid this cycle
- busy  out  1  state not IDLE/READY
- loaded  out  1  full tile resident
- done  out  1  one-cycle pulse at feed end

Behaviour:
- Constants:
  - WPB = ENTRYS/8, words per bank.
  - TOTAL = 64*WPB.
  - FEED_LEN = ENTRYS+7 with skew, ENTRYS without.
- State machine:
  - IDLE: load_start -> CLEAR.
  - CLEAR, 1 cycle: sram_rst=1; -> LOAD.
  - LOAD:
    - in_ready=1.
    - Each accepted word w (0..TOTAL-1) asserts sram_we[unit][bank] in the same cycle, with unit = w/(8*WPB) and bank = (w/WPB)%8.
    - Accept of word TOTAL-1 -> READY.
    - in_valid low stalls with no we.
  - READY:
    - loaded=1.
    - feed_start -> FEED with cycle counter t=0.
    - load_start -> CLEAR (reload). If both are asserted, load_start wins.
  - FEED:
    - For unit i, sram_re[i]=1 and sram_rdaddr[i]=t-i when 0 <= t-i < ENTRYS; otherwise re=0 and rdaddr=0.
    - At t = FEED_LEN-1 -> DONE.
  - DONE, 1 cycle: done=1, loaded stays 1; -> READY.
- row_valid[i] is sram_re[i] registered, i.e. 1-cycle SRAM read latency.
- in_ready=0 outside LOAD. Words offered outside LOAD are not consumed.
- feed_start in IDLE/CLEAR/LOAD/FEED/DONE: ignored.
- load_start in CLEAR/LOAD/FEED/DONE: ignored.
- Reset (also mid-LOAD or mid-FEED): state IDLE, counters 0, loaded=0.
- Reset values: all of these are 0 — in_ready, sram_rst, sram_we, sram_rdaddr, sram_re, row_valid, busy, loaded, done.
- A reset mid-load leaves a partial tile; loaded=0 until a full reload.
- Word counter width is $clog2(TOTAL)+1; feed counter width is $clog2(ENTRYS+8). Neither wraps.

Optional Feature:
- SRAM_A_SEQ_SKEW_EN defined:
  - Per-unit skew as above; FEED_LEN = ENTRYS+7.
- Undefined:
  - All units use rdaddr=t and re=1 for t < ENTRYS.
  - FEED_LEN = ENTRYS.
  - row_valid bits all equal.

Decomposition:
- Package sram_seq_pkg:
  - state enum {IDLE, CLEAR, LOAD, READY, FEED, DONE}
  - NUM_UNITS=8, NUM_BANKS=8, NIBBLES_PER_WORD=8
- One sub-module, sram_skew_addr_gen:
  - Inputs t, feed_active.
  - Outputs per-unit rdaddr/re; honours the skew macro.

Test Plan (ENTRYS=16 unless noted):
- Reset, then idle 5 cycles -> all outputs 0, in_ready=0.
- load_start, then 128 back-to-back words with in_data=w:
  - sram_rst high exactly 1 cycle.
  - Word 0 -> we[0][0]; word 2 -> we[0][1]; word 16 -> we[1][0]; word 127 -> we[7][7].
  - loaded=1 the cycle after word 127.
- Same load with in_valid toggling every other cycle -> 128 we pulses total, none in stall cycles, no duplicate index.
- feed_start in READY, skew on:
  - Unit 0 re at t=0..15, rdaddr 0..15.
  - Unit 7 re at t=7..22.
  - row_valid[7] high t=8..23.
  - done at cycle 23 after FEED entry, then READY.
- Skew macro off -> all 8 rdaddr equal to t for t=0..15; done after 16 cycles.
- rst asserted at FEED t=5 -> next cycle all sram_re=0, loaded=0.
- feed_start then blocked until a new 128-word load completes.

Source files
------------

// File: rtl/sram_seq_pkg.sv
// rtl/sram_seq_pkg.sv - shared state encoding and array geometry for the A-operand SRAM sequencer
package sram_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        READY,
        FEED,
        DONE
    } state_e;

    localparam int NUM_UNITS        = 8;
    localparam int NUM_BANKS        = 8;
    localparam int NIBBLES_PER_WORD = 8;

endpackage

// File: rtl/sram_skew_addr_gen.sv
// rtl/sram_skew_addr_gen.sv - per-unit read address/enable generator; skew controlled by SRAM_A_SEQ_SKEW_EN
module sram_skew_addr_gen
    import sram_seq_pkg::*;
#(
    parameter int ENTRYS = 16,
    parameter int TW     = $clog2(ENTRYS + 8),
    parameter int AW     = $clog2(ENTRYS)
) (
    input  logic [TW-1:0]                t,
    input  logic                         feed_active,
    output logic [NUM_UNITS-1:0][AW-1:0] rdaddr,
    output logic [NUM_UNITS-1:0]         re
);

    // Unit i reads entry t-i (skewed) or t (unskewed) while that entry is in range.
    always_comb begin
        rdaddr = '0;
        re     = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
`ifdef SRAM_A_SEQ_SKEW_EN
            if (feed_active && (t >= TW'(i)) && ((t - TW'(i)) < TW'(ENTRYS))) begin
                re[i]     = 1'b1;
                rdaddr[i] = AW'(t - TW'(i));
            end
`else
            if (feed_active && (t < TW'(ENTRYS))) begin
                re[i]     = 1'b1;
                rdaddr[i] = AW'(t);
            end
`endif
        end
    end

endmodule

// File: rtl/sram_a_seq_ctrl.sv
// rtl/sram_a_seq_ctrl.sv - load/feed sequencer for the 8x8-bank A-operand SRAM; skew via SRAM_A_SEQ_SKEW_EN
module sram_a_seq_ctrl
    import sram_seq_pkg::*;
#(
    parameter int ENTRYS  = 16,
    parameter int WRWIDTH = 32,
    parameter int RDWIDTH = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  load_start,
    input  logic                                                  feed_start,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [WRWIDTH-1:0]                                    in_data,
    output logic                                                  sram_rst,
    output logic [NUM_UNITS-1:0][NUM_BANKS-1:0]                   sram_we,
    output logic [NUM_UNITS-1:0][NUM_BANKS-1:0][WRWIDTH-1:0]      sram_data_in,
    output logic [NUM_UNITS-1:0][$clog2(ENTRYS)-1:0]              sram_rdaddr,
    output logic [NUM_UNITS-1:0]                                  sram_re,
    output logic [NUM_UNITS-1:0]                                  row_valid,
    output logic                                                  busy,
    output logic                                                  loaded,
    output logic                                                  done
);

    localparam int WPB   = ENTRYS / NIBBLES_PER_WORD;
    localparam int TOTAL = NUM_UNITS * NUM_BANKS * WPB;
    localparam int WCW   = $clog2(TOTAL) + 1;
    localparam int TW    = $clog2(ENTRYS + 8);
    localparam int AW    = $clog2(ENTRYS);
    localparam int UW    = $clog2(NUM_UNITS);
    localparam int BW    = $clog2(NUM_BANKS);
`ifdef SRAM_A_SEQ_SKEW_EN
    localparam int FEED_LEN = ENTRYS + NUM_UNITS - 1;
`else
    localparam int FEED_LEN = ENTRYS;
`endif

    if (WRWIDTH != RDWIDTH * NIBBLES_PER_WORD) begin : g_bad_width
        $error("WRWIDTH must hold exactly NIBBLES_PER_WORD read nibbles");
    end
    if ((ENTRYS % NIBBLES_PER_WORD) != 0 || ENTRYS < NIBBLES_PER_WORD) begin : g_bad_entrys
        $error("ENTRYS must be a non-zero multiple of NIBBLES_PER_WORD");
    end

    state_e               state_q, state_d;
    logic [WCW-1:0]       word_cnt_q, word_cnt_d;
    logic [TW-1:0]        t_q, t_d;
    logic                 loaded_q, loaded_d;
    logic [NUM_UNITS-1:0] row_valid_q, row_valid_d;

    logic                 accept;
    logic [UW-1:0]        we_unit;
    logic [BW-1:0]        we_bank;

    assign accept  = (state_q == LOAD) && in_valid;
    assign we_unit = UW'(word_cnt_q / WCW'(NUM_BANKS * WPB));
    assign we_bank = BW'((word_cnt_q / WCW'(WPB)) % WCW'(NUM_BANKS));

    sram_skew_addr_gen #(
        .ENTRYS (ENTRYS),
        .TW     (TW),
        .AW     (AW)
    ) u_addr_gen (
        .t           (t_q),
        .feed_active (state_q == FEED),
        .rdaddr      (sram_rdaddr),
        .re          (sram_re)
    );

    // Steer the accepted word to its bank; words fill a bank, then the next bank, then the next unit.
    always_comb begin
        sram_we = '0;
        if (accept) begin
            sram_we[we_unit][we_bank] = 1'b1;
        end
    end

    assign sram_data_in = {(NUM_UNITS * NUM_BANKS){in_data}};
    assign in_ready     = (state_q == LOAD);
    assign sram_rst     = (state_q == CLEAR);
    assign busy         = (state_q != IDLE) && (state_q != READY);
    assign loaded       = loaded_q;
    assign done         = (state_q == DONE);
    assign row_valid    = row_valid_q;

    // Next-state logic; load_start has priority over feed_start in READY.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        t_d         = t_q;
        loaded_d    = loaded_q;
        row_valid_d = sram_re;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = CLEAR;
                    loaded_d = 1'b0;
                end
            end
            CLEAR: begin
                state_d    = LOAD;
                word_cnt_d = '0;
                loaded_d   = 1'b0;
            end
            LOAD: begin
                if (accept) begin
                    if (word_cnt_q == WCW'(TOTAL - 1)) begin
                        state_d    = READY;
                        loaded_d   = 1'b1;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            READY: begin
                if (load_start) begin
                    state_d  = CLEAR;
                    loaded_d = 1'b0;
                end else if (feed_start) begin
                    state_d = FEED;
                    t_d     = '0;
                end
            end
            FEED: begin
                if (t_q == TW'(FEED_LEN - 1)) begin
                    state_d = DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            DONE: begin
                state_d = READY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            t_q         <= '0;
            loaded_q    <= 1'b0;
            row_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            t_q         <= t_d;
            loaded_q    <= loaded_d;
            row_valid_q <= row_valid_d;
        end
    end

endmodule

// File: tb/tb_sram_a_seq_ctrl.sv
// tb/tb_sram_a_seq_ctrl.sv - self-checking bench for sram_a_seq_ctrl
module tb_sram_a_seq_ctrl;

    localparam int ENTRYS = 16;
`ifdef SRAM_A_SEQ_SKEW_EN
    localparam int FEED_LEN = ENTRYS + 7;
`else
    localparam int FEED_LEN = ENTRYS;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      load_start;
    logic                      feed_start;
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_data;
    logic                      sram_rst;
    logic [7:0][7:0]           sram_we;
    logic [7:0][7:0][31:0]     sram_data_in;
    logic [7:0][3:0]           sram_rdaddr;
    logic [7:0]                sram_re;
    logic [7:0]                row_valid;
    logic                      busy;
    logic                      loaded;
    logic                      done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int w;
        int unit;
        int bank;
    } we_vec_t;

    we_vec_t ld_tab[7];

    sram_a_seq_ctrl #(
        .ENTRYS  (ENTRYS),
        .WRWIDTH (32),
        .RDWIDTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .feed_start   (feed_start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .sram_rst     (sram_rst),
        .sram_we      (sram_we),
        .sram_data_in (sram_data_in),
        .sram_rdaddr  (sram_rdaddr),
        .sram_re      (sram_re),
        .row_valid    (row_valid),
        .busy         (busy),
        .loaded       (loaded),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] idle_vec();
        return 64'({sram_re, row_valid, in_ready, sram_rst, busy, loaded, done,
                    |sram_we, |sram_rdaddr});
    endfunction

    // Full 128-word load; toggle inserts a stall cycle before every word.
    task automatic run_load(input bit toggle, input bit check_tab);
        int          we_q[$];
        int          accepted   = 0;
        int          cyc        = 0;
        int          rst_pulses = 0;
        int          stall_we   = 0;
        int          seq_err    = 0;
        int          data_err   = 0;
        int          ready_err  = 0;
        int          dup_err    = 0;
        int          hits[64];
        int          n_set;
        int          act_idx;
        int          exp_idx;
        logic [63:0] we_flat;

        foreach (hits[k]) hits[k] = 0;
        load_start = 1'b1;
        #1;
        step();
        load_start = 1'b0;
        #1;
        rst_pulses += int'(sram_rst);
        chk("clear_in_ready", 64'(in_ready), 64'd0);
        chk("clear_busy", 64'(busy), 64'd1);
        chk("clear_loaded", 64'(loaded), 64'd0);
        step();
        while (accepted < 128 && cyc < 1000) begin
            in_valid = toggle ? (cyc % 2 == 1) : 1'b1;
            in_data  = 32'(accepted);
            if (in_valid) begin
                we_q.push_back((accepted / 16) * 8 + (accepted / 2) % 8);
            end
            #1;
            rst_pulses += int'(sram_rst);
            if (!in_ready) ready_err++;
            we_flat = sram_we;
            n_set   = 0;
            act_idx = -1;
            for (int k = 0; k < 64; k++) begin
                if (we_flat[k]) begin
                    n_set++;
                    act_idx = k;
                end
            end
            if (in_valid && in_ready) begin
                exp_idx = (we_q.size() > 0) ? we_q.pop_front() : -2;
                if (n_set != 1 || act_idx != exp_idx) seq_err++;
                if (act_idx >= 0) hits[act_idx]++;
                if (sram_data_in[7][3] != in_data || sram_data_in[0][0] != in_data) data_err++;
                if (check_tab) begin
                    foreach (ld_tab[j]) begin
                        if (ld_tab[j].w == accepted) begin
                            chk($sformatf("we_word%0d", accepted), we_flat,
                                64'd1 << (ld_tab[j].unit * 8 + ld_tab[j].bank));
                        end
                    end
                    if (accepted == 127) chk("loaded_before_last", 64'(loaded), 64'd0);
                end
                accepted++;
            end else if (n_set != 0) begin
                stall_we++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        #1;
        foreach (hits[k]) if (hits[k] != 2) dup_err++;
        chk("load_words", 64'(accepted), 64'd128);
        chk("load_we_sequence", 64'(seq_err), 64'd0);
        chk("load_stall_we", 64'(stall_we), 64'd0);
        chk("load_bank_hits", 64'(dup_err), 64'd0);
        chk("load_data_bcast", 64'(data_err), 64'd0);
        chk("load_in_ready", 64'(ready_err), 64'd0);
        chk("sram_rst_pulses", 64'(rst_pulses), 64'd1);
        chk("loaded_after_load", 64'(loaded), 64'd1);
        chk("busy_after_load", 64'(busy), 64'd0);
    endtask

    // Feed from READY; row_valid expectations travel through a one-deep scoreboard queue.
    task automatic run_feed();
        logic [7:0]      exp_re;
        logic [7:0][3:0] exp_addr;
        logic [7:0]      rv_q[$];
        logic [7:0]      exp_rv;

        feed_start = 1'b1;
        #1;
        rv_q.push_back(8'h00);
        step();
        feed_start = 1'b0;
        for (int k = 0; k <= FEED_LEN + 1; k++) begin
            exp_re   = '0;
            exp_addr = '0;
            for (int i = 0; i < 8; i++) begin
`ifdef SRAM_A_SEQ_SKEW_EN
                if (k - i >= 0 && k - i < ENTRYS && k < FEED_LEN) begin
                    exp_re[i]   = 1'b1;
                    exp_addr[i] = 4'(k - i);
                end
`else
                if (k < ENTRYS) begin
                    exp_re[i]   = 1'b1;
                    exp_addr[i] = 4'(k);
                end
`endif
            end
            exp_rv = rv_q.pop_front();
            chk($sformatf("feed_re_t%0d", k), 64'(sram_re), 64'(exp_re));
            chk($sformatf("feed_addr_t%0d", k), 64'(sram_rdaddr), 64'(exp_addr));
            chk($sformatf("feed_row_valid_t%0d", k), 64'(row_valid), 64'(exp_rv));
            chk($sformatf("feed_done_t%0d", k), 64'(done), 64'(k == FEED_LEN));
            chk($sformatf("feed_busy_t%0d", k), 64'(busy), 64'(k <= FEED_LEN));
            rv_q.push_back(exp_re);
            step();
        end
        chk("feed_end_loaded", 64'(loaded), 64'd1);
        chk("feed_end_in_ready", 64'(in_ready), 64'd0);
    endtask

    initial begin
        ld_tab[0] = '{w: 0,   unit: 0, bank: 0};
        ld_tab[1] = '{w: 1,   unit: 0, bank: 0};
        ld_tab[2] = '{w: 2,   unit: 0, bank: 1};
        ld_tab[3] = '{w: 16,  unit: 1, bank: 0};
        ld_tab[4] = '{w: 37,  unit: 2, bank: 2};
        ld_tab[5] = '{w: 63,  unit: 3, bank: 7};
        ld_tab[6] = '{w: 127, unit: 7, bank: 7};

        rst        = 1'b1;
        load_start = 1'b0;
        feed_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_outputs", idle_vec(), 64'd0);

        // Idle with a word and a feed request offered: nothing may move.
        in_valid   = 1'b1;
        in_data    = 32'hdead_beef;
        feed_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("idle_outputs_c%0d", k), idle_vec(), 64'd0);
        end
        in_valid   = 1'b0;
        feed_start = 1'b0;
        step();

        run_load(1'b0, 1'b1);
        run_feed();

        run_load(1'b1, 1'b0);

        // Reset at FEED t=5 drops everything and the tile is no longer resident.
        feed_start = 1'b1;
        #1;
        step();
        feed_start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("pre_reset_re0", 64'(sram_re[0]), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_feed_reset_re", 64'(sram_re), 64'd0);
        chk("mid_feed_reset_loaded", 64'(loaded), 64'd0);
        chk("mid_feed_reset_busy", 64'(busy), 64'd0);

        feed_start = 1'b1;
        #1;
        step();
        feed_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("blocked_feed_c%0d", k), idle_vec(), 64'd0);
            step();
        end

        run_load(1'b0, 1'b0);
        run_feed();

        // Both commands in READY: the reload wins.
        load_start = 1'b1;
        feed_start = 1'b1;
        #1;
        step();
        load_start = 1'b0;
        feed_start = 1'b0;
        chk("both_start_sram_rst", 64'(sram_rst), 64'd1);
        chk("both_start_re", 64'(sram_re), 64'd0);
        step();
        chk("both_start_in_ready", 64'(in_ready), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
